// File: rtl/aud_codec_emu.sv
// aud_codec_emu: I2S master emulating the codec side of the link (BCLK, shared LRCK, ADCDAT out, DACDAT in).
// Optional build macro AUD_CODEC_EMU_LOOPBACK_EN feeds the RX deserializer from the internal ADCDAT register.
module aud_codec_emu #(
    parameter int BCLK_DIV    = 2,
    parameter int BITS_PER_CH = 32,
    parameter int DATA_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_tx_left,
    input  logic [DATA_W-1:0] i_tx_right,
    output logic              o_tx_ready,
    output logic              o_bclk,
    output logic              o_lrck,
    output logic              o_adcdat,
    input  logic              i_dacdat,
    output logic [DATA_W-1:0] o_rx_left,
    output logic [DATA_W-1:0] o_rx_right,
    output logic              o_rx_valid
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BC_W  = $clog2(2 * BITS_PER_CH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * BITS_PER_CH - 1);
    localparam logic [BC_W-1:0]  BPC_C    = BC_W'(BITS_PER_CH);
    localparam logic [BC_W-1:0]  DW_C     = BC_W'(DATA_W);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_ZERO  = BC_W'(0);

    // Slot index within the current channel half-frame.
    function automatic logic [BC_W-1:0] slot_of(input logic [BC_W-1:0] bc);
        logic [BC_W-1:0] k;
        if (bc >= BPC_C) begin
            k = bc - BPC_C;
        end else begin
            k = bc;
        end
        return k;
    endfunction

    // Slots 1..DATA_W carry sample bits; slot 0 is the I2S one-bit delay.
    function automatic logic data_slot(input logic [BC_W-1:0] k);
        return (k >= BC_ONE) && (k <= DW_C);
    endfunction

    // MSB-first bit of a sample for a given data slot.
    function automatic logic tx_bit(input logic [DATA_W-1:0] word, input logic [BC_W-1:0] k);
        logic [DATA_W-1:0] shifted;
        shifted = word >> (DW_C - k);
        return shifted[0];
    endfunction

    logic [DIV_W-1:0]  div_r;
    logic [BC_W-1:0]   bc_r;
    logic              started_r;
    logic              bclk_r;
    logic              lrck_r;
    logic              adcdat_r;
    logic              tx_ready_r;
    logic              rx_valid_r;
    logic [DATA_W-1:0] tx_left_sh_r;
    logic [DATA_W-1:0] tx_right_sh_r;
    logic [DATA_W-1:0] rx_sh_r;
    logic [DATA_W-1:0] rx_left_r;
    logic [DATA_W-1:0] rx_right_r;

    logic              rise_s;
    logic              fall_s;
    logic [BC_W-1:0]   nbc_s;
    logic              nhalf_s;
    logic [BC_W-1:0]   nk_s;
    logic              frame_start_s;
    logic              tx_next_s;
    logic [BC_W-1:0]   k_s;
    logic              rx_shift_s;
    logic              rx_last_s;
    logic              rx_din_s;
    logic [DATA_W-1:0] rx_word_s;

`ifdef AUD_CODEC_EMU_LOOPBACK_EN
    assign rx_din_s = adcdat_r;
`else
    assign rx_din_s = i_dacdat;
`endif

    // BCLK edge decode and next-slot TX/RX decisions.
    always_comb begin
        rise_s        = 1'b0;
        fall_s        = 1'b0;
        nbc_s         = BC_ZERO;
        tx_next_s     = 1'b0;
        frame_start_s = 1'b0;
        if (i_en && (div_r == DIV_LAST)) begin
            rise_s = ~bclk_r;
            fall_s = bclk_r;
        end else begin
            rise_s = 1'b0;
            fall_s = 1'b0;
        end
        // The very first fall after enable is frame start regardless of bc.
        if (!started_r || (bc_r == BC_LAST)) begin
            nbc_s = BC_ZERO;
        end else begin
            nbc_s = bc_r + BC_ONE;
        end
        nhalf_s = (nbc_s >= BPC_C);
        nk_s    = slot_of(nbc_s);
        if (data_slot(nk_s)) begin
            tx_next_s = nhalf_s ? tx_bit(tx_right_sh_r, nk_s) : tx_bit(tx_left_sh_r, nk_s);
        end else begin
            tx_next_s = 1'b0;
        end
        frame_start_s = fall_s && (nbc_s == BC_ZERO);
        k_s           = slot_of(bc_r);
        rx_shift_s    = rise_s && started_r && data_slot(k_s);
        rx_last_s     = (k_s == DW_C);
        rx_word_s     = {rx_sh_r[DATA_W-2:0], rx_din_s};
    end

    // Link state: divider, bit counter, serializer and deserializer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_r         <= DIV_ZERO;
            bc_r          <= BC_ZERO;
            started_r     <= 1'b0;
            bclk_r        <= 1'b0;
            lrck_r        <= 1'b0;
            adcdat_r      <= 1'b0;
            tx_ready_r    <= 1'b0;
            rx_valid_r    <= 1'b0;
            tx_left_sh_r  <= {DATA_W{1'b0}};
            tx_right_sh_r <= {DATA_W{1'b0}};
            rx_sh_r       <= {DATA_W{1'b0}};
            rx_left_r     <= {DATA_W{1'b0}};
            rx_right_r    <= {DATA_W{1'b0}};
        end else if (!i_en) begin
            // Idle link discards the partial frame but keeps the last received pair.
            div_r         <= DIV_ZERO;
            bc_r          <= BC_ZERO;
            started_r     <= 1'b0;
            bclk_r        <= 1'b0;
            lrck_r        <= 1'b0;
            adcdat_r      <= 1'b0;
            tx_ready_r    <= 1'b0;
            rx_valid_r    <= 1'b0;
            tx_left_sh_r  <= {DATA_W{1'b0}};
            tx_right_sh_r <= {DATA_W{1'b0}};
            rx_sh_r       <= {DATA_W{1'b0}};
        end else begin
            tx_ready_r <= 1'b0;
            rx_valid_r <= 1'b0;
            if (div_r == DIV_LAST) begin
                div_r  <= DIV_ZERO;
                bclk_r <= ~bclk_r;
            end else begin
                div_r  <= div_r + DIV_ONE;
            end
            if (fall_s) begin
                bc_r      <= nbc_s;
                started_r <= 1'b1;
                lrck_r    <= nhalf_s;
                adcdat_r  <= tx_next_s;
            end
            if (frame_start_s) begin
                tx_left_sh_r  <= i_tx_left;
                tx_right_sh_r <= i_tx_right;
                tx_ready_r    <= 1'b1;
            end
            if (rx_shift_s) begin
                rx_sh_r <= rx_word_s;
                if (rx_last_s) begin
                    if (bc_r >= BPC_C) begin
                        rx_right_r <= rx_word_s;
                        rx_valid_r <= 1'b1;
                    end else begin
                        rx_left_r  <= rx_word_s;
                    end
                end
            end
        end
    end

    assign o_bclk     = bclk_r;
    assign o_lrck     = lrck_r;
    assign o_adcdat   = adcdat_r;
    assign o_tx_ready = tx_ready_r;
    assign o_rx_valid = rx_valid_r;
    assign o_rx_left  = rx_left_r;
    assign o_rx_right = rx_right_r;

endmodule

// File: tb/tb_aud_codec_emu.sv
// Self-checking bench for aud_codec_emu: a cycle model derived from time-since-enable arithmetic,
// a directed frame table, en-drop/re-enable and mid-frame reset sequences, and randomized traffic.
module tb_aud_codec_emu;

    localparam int DIV = 2;
    localparam int BPC = 32;
    localparam int DW  = 16;
    localparam int HP  = 2 * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          dacdat = 1'b0;
    logic [DW-1:0] tx_l = '0;
    logic [DW-1:0] tx_r = '0;
    logic          o_tx_ready, o_bclk, o_lrck, o_adcdat, o_rx_valid;
    logic [DW-1:0] o_rx_left, o_rx_right;

    aud_codec_emu #(.BCLK_DIV(DIV), .BITS_PER_CH(BPC), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_tx_left(tx_l), .i_tx_right(tx_r), .o_tx_ready(o_tx_ready),
        .o_bclk(o_bclk), .o_lrck(o_lrck), .o_adcdat(o_adcdat), .i_dacdat(dacdat),
        .o_rx_left(o_rx_left), .o_rx_right(o_rx_right), .o_rx_valid(o_rx_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n = 0;
    int valid_seen = 0;
    logic [DW-1:0] lat_l [0:63];
    logic [DW-1:0] lat_r [0:63];
    logic [DW-1:0] pl_l [0:63];
    logic [DW-1:0] pl_r [0:63];
    logic [DW-1:0] play_l = '0;
    logic [DW-1:0] play_r = '0;
    logic [DW-1:0] m_rx_l = '0;
    logic [DW-1:0] m_rx_r = '0;

    typedef struct {
        logic [DW-1:0] tx_l;
        logic [DW-1:0] tx_r;
        logic [DW-1:0] dac_l;
        logic [DW-1:0] dac_r;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] src_l(input int f);
`ifdef AUD_CODEC_EMU_LOOPBACK_EN
        return lat_l[f];
`else
        return pl_l[f];
`endif
    endfunction

    function automatic logic [DW-1:0] src_r(input int f);
`ifdef AUD_CODEC_EMU_LOOPBACK_EN
        return lat_r[f];
`else
        return pl_r[f];
`endif
    endfunction

    // One clock: advance the model from the count of consecutive enabled edges, compare, drive DACDAT.
    task automatic step();
        int j, bc, k, f;
        logic e_bclk, e_lrck, e_adc, e_rdy, e_val;
        @(posedge clk);
        if (!rst_n) begin
            n = 0;
            m_rx_l = '0;
            m_rx_r = '0;
        end else if (en) begin
            n++;
        end else begin
            n = 0;
        end
        if (n >= HP && n % HP == 0 && ((n / HP - 1) % (2 * BPC)) == 0) begin
            f = ((n / HP - 1) / (2 * BPC)) % 64;
            lat_l[f] = tx_l;
            lat_r[f] = tx_r;
            pl_l[f]  = play_l;
            pl_r[f]  = play_r;
        end
        #1;
        e_bclk = ((n / DIV) % 2) == 1;
        e_lrck = 1'b0; e_adc = 1'b0; e_rdy = 1'b0; e_val = 1'b0;
        if (n >= HP) begin
            j  = n / HP - 1;
            bc = j % (2 * BPC);
            f  = (j / (2 * BPC)) % 64;
            k  = bc % BPC;
            e_lrck = bc >= BPC;
            if (k >= 1 && k <= DW) e_adc = (bc >= BPC) ? lat_r[f][DW-k] : lat_l[f][DW-k];
            e_rdy = (n % HP == 0) && (bc == 0);
        end
        if (n >= HP + DIV && (n - DIV) % HP == 0) begin
            j  = (n - DIV) / HP - 1;
            bc = j % (2 * BPC);
            f  = (j / (2 * BPC)) % 64;
            if (bc == DW) m_rx_l = src_l(f);
            if (bc == BPC + DW) begin
                m_rx_r = src_r(f);
                e_val = 1'b1;
            end
        end
        if (o_rx_valid === 1'b1) valid_seen++;
        chk("bclk", 64'(o_bclk), 64'(e_bclk));
        chk("lrck", 64'(o_lrck), 64'(e_lrck));
        chk("adcdat", 64'(o_adcdat), 64'(e_adc));
        chk("tx_ready", 64'(o_tx_ready), 64'(e_rdy));
        chk("rx_valid", 64'(o_rx_valid), 64'(e_val));
        chk("rx_left", 64'(o_rx_left), 64'(m_rx_l));
        chk("rx_right", 64'(o_rx_right), 64'(m_rx_r));
        if (n >= HP && n % HP == 0) begin
            j  = n / HP - 1;
            bc = j % (2 * BPC);
            f  = (j / (2 * BPC)) % 64;
            k  = bc % BPC;
`ifdef AUD_CODEC_EMU_LOOPBACK_EN
            dacdat = 1'($urandom);
`else
            if (k >= 1 && k <= DW) dacdat = (bc >= BPC) ? pl_r[f][DW-k] : pl_l[f][DW-k];
            else dacdat = 1'($urandom);
`endif
        end
    endtask

    initial begin
        logic [63:0] stream;
        logic [63:0] exp_stream;
        vecs[0] = '{16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, 16'h0, 16'h0};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0, 16'h0};
        vecs[2] = '{16'h0000, 16'h8000, 16'hAAAA, 16'h5555, 16'h0, 16'h0};
        vecs[3] = '{16'h7FFF, 16'hC3A5, 16'hFFFF, 16'h0001, 16'h0, 16'h0};
        for (int i = 0; i < 4; i++) begin
`ifdef AUD_CODEC_EMU_LOOPBACK_EN
            vecs[i].exp_l = vecs[i].tx_l;
            vecs[i].exp_r = vecs[i].tx_r;
`else
            vecs[i].exp_l = vecs[i].dac_l;
            vecs[i].exp_r = vecs[i].dac_r;
`endif
        end

        // Reset with link idle, then 100 idle cycles with BCLK held low.
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step();

        // Directed frames from the table.
        for (int v = 0; v < 4; v++) begin
            tx_l = vecs[v].tx_l; tx_r = vecs[v].tx_r;
            play_l = vecs[v].dac_l; play_r = vecs[v].dac_r;
            en = 1'b1;
            valid_seen = 0;
            stream = '0;
            for (int c = 0; c < 2 * BPC * HP + DIV; c++) begin
                step();
                if (n >= HP + DIV && (n - DIV) % HP == 0 && ((n - DIV) / HP - 1) < 2 * BPC)
                    stream = {stream[62:0], o_adcdat};
            end
            exp_stream = {1'b0, vecs[v].tx_l, 15'b0, 1'b0, vecs[v].tx_r, 15'b0};
            chk("adc_stream", stream, exp_stream);
            chk("vec_rx_left", 64'(o_rx_left), 64'(vecs[v].exp_l));
            chk("vec_rx_right", 64'(o_rx_right), 64'(vecs[v].exp_r));
            chk("vec_valid_count", 64'(valid_seen), 64'd1);
            en = 1'b0;
            for (int c = 0; c < 6; c++) step();
        end

        // Drop enable at BCLK 10 of the left half, then re-enable.
        tx_l = 16'h1357; tx_r = 16'h2468; play_l = 16'hDEAD; play_r = 16'hBEEF;
        en = 1'b1;
        for (int c = 0; c < HP * 11 + 1; c++) step();
        en = 1'b0;
        valid_seen = 0;
        step();
        chk("drop_bclk", 64'(o_bclk), 64'd0);
        chk("drop_lrck", 64'(o_lrck), 64'd0);
        chk("drop_rx_left", 64'(o_rx_left), 64'(vecs[3].exp_l));
        for (int c = 0; c < 300; c++) step();
        chk("drop_no_valid", 64'(valid_seen), 64'd0);
        en = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("reen_ready", 64'(o_tx_ready), 64'd1);
        for (int c = 0; c < 20; c++) step();

        // Randomized traffic with occasional enable drops and mid-frame input changes.
        for (int c = 0; c < 1500; c++) begin
            tx_l = 16'($urandom); tx_r = 16'($urandom);
            play_l = 16'($urandom); play_r = 16'($urandom);
            if (!en) en = 1'b1;
            else if ($urandom_range(0, 599) == 0) en = 1'b0;
            step();
        end

        // Asynchronous reset in the middle of a frame.
        en = 1'b1;
        for (int c = 0; c < 100; c++) step();
        rst_n = 1'b0;
        #1;
        chk("arst_bclk", 64'(o_bclk), 64'd0);
        chk("arst_lrck", 64'(o_lrck), 64'd0);
        chk("arst_rx", {32'(o_rx_left), 32'(o_rx_right)}, 64'd0);
        chk("arst_pulses", {62'd0, o_tx_ready, o_rx_valid}, 64'd0);
        for (int c = 0; c < 2; c++) step();
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tx_l = 16'($urandom); tx_r = 16'($urandom);
            play_l = 16'($urandom); play_r = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
